// File: rtl/burst_line_engine.sv
// burst_line_engine: moves one cache line between the client and the BurstRAM command port,
// gathering reads beat by beat and scattering masked writes, with a read watchdog.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | ready for a client request; request fields latched on accept
// S_ISSUE    | waiting for !br_busy; the cmd_en cycle also carries write beat 0
// S_WR_BURST | streaming write beats 1..BURST_COUNT-1 back to back
// S_RD_WAIT  | collecting read beats, watchdog running
// S_DONE     | one-cycle completion pulse
module burst_line_engine #(
    parameter int DATA_BITWIDTH  = 64,
    parameter int DEPTH_BITWIDTH = 8,
    parameter int BURST_COUNT    = 4,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int MB                 = DATA_BITWIDTH / 8,
    localparam int BEAT_BITS          = $clog2(BURST_COUNT),
    localparam int LINE_ADDR_BITWIDTH = DEPTH_BITWIDTH - BEAT_BITS,
    localparam int TMO_BITS           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic                                  req_write,
    input  logic [LINE_ADDR_BITWIDTH-1:0]         req_line_addr,
    input  logic [DATA_BITWIDTH*BURST_COUNT-1:0]  wr_line,
    input  logic [MB*BURST_COUNT-1:0]             wr_line_mask,
    output logic [DATA_BITWIDTH*BURST_COUNT-1:0]  rd_line,
    output logic                                  done,
    output logic                                  err,
    output logic                                  br_cmd,
    output logic                                  br_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0]             br_addr,
    output logic [DATA_BITWIDTH-1:0]              br_wr_data,
    output logic [MB-1:0]                         br_data_mask,
    input  logic [DATA_BITWIDTH-1:0]              br_rd_data,
    input  logic                                  br_rd_data_valid,
    input  logic                                  br_busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ISSUE    = 3'd1;
    localparam logic [2:0] S_WR_BURST = 3'd2;
    localparam logic [2:0] S_RD_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BURST_COUNT - 1);
    localparam logic [BEAT_BITS-1:0] BEAT_ONE  = BEAT_BITS'(1);
    localparam logic [TMO_BITS-1:0]  TMO_LIMIT = TMO_BITS'(TIMEOUT_CYCLES);
    localparam logic [TMO_BITS-1:0]  TMO_ONE   = TMO_BITS'(1);

    logic [2:0]                              state;
    logic                                    wr_q;
    logic [DATA_BITWIDTH*BURST_COUNT-1:0]    wr_line_q;
    logic [MB*BURST_COUNT-1:0]               mask_q;
    logic [BEAT_BITS-1:0]                    beat;
    logic [TMO_BITS-1:0]                     tmo_cnt;
    logic [BEAT_BITS-1:0]                    out_beat;
    logic                                    wr_drive;
    logic                                    last_rd_beat;
    logic                                    timeout;

    assign req_ready = (state == S_IDLE);
    assign done      = (state == S_DONE);
    assign br_cmd_en = (state == S_ISSUE) && !br_busy;

    // The last beat wins over a watchdog expiry landing in the same cycle.
    assign last_rd_beat = (state == S_RD_WAIT) && br_rd_data_valid && (beat == LAST_BEAT);
    assign timeout      = (state == S_RD_WAIT) && !last_rd_beat && ((tmo_cnt + TMO_ONE) >= TMO_LIMIT);
    assign err          = timeout;

    assign out_beat     = (state == S_WR_BURST) ? beat : '0;
    assign wr_drive     = ((state == S_ISSUE) && wr_q) || (state == S_WR_BURST);
    assign br_wr_data   = wr_drive ? wr_line_q[out_beat*DATA_BITWIDTH +: DATA_BITWIDTH] : '0;
    assign br_data_mask = wr_drive ? mask_q[out_beat*MB +: MB] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            wr_q      <= 1'b0;
            wr_line_q <= '0;
            mask_q    <= '0;
            beat      <= '0;
            tmo_cnt   <= '0;
            br_cmd    <= 1'b0;
            br_addr   <= '0;
            rd_line   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wr_q      <= req_write;
                        wr_line_q <= wr_line;
                        mask_q    <= wr_line_mask;
                        br_cmd    <= req_write;
                        br_addr   <= {req_line_addr, {BEAT_BITS{1'b0}}};
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!br_busy) begin
                        if (wr_q) begin
                            beat  <= BEAT_ONE;
                            state <= S_WR_BURST;
                        end else begin
                            beat    <= '0;
                            tmo_cnt <= '0;
                            state   <= S_RD_WAIT;
                        end
                    end
                end
                S_WR_BURST: begin
                    if (beat == LAST_BEAT) begin
                        state <= S_DONE;
                    end else begin
                        beat <= beat + BEAT_ONE;
                    end
                end
                S_RD_WAIT: begin
                    if (br_rd_data_valid) begin
                        rd_line[beat*DATA_BITWIDTH +: DATA_BITWIDTH] <= br_rd_data;
                    end
                    if (last_rd_beat) begin
                        state <= S_DONE;
                    end else if (timeout) begin
                        state <= S_IDLE;
                    end else begin
                        if (br_rd_data_valid && (beat != LAST_BEAT)) begin
                            beat <= beat + BEAT_ONE;
                        end
                        if (tmo_cnt != TMO_LIMIT) begin
                            tmo_cnt <= tmo_cnt + TMO_ONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_line_engine.sv
// tb_burst_line_engine: BurstRAM bus model plus a line-level reference memory; a scoreboard
// queue of expected completions is checked by an independent monitor.
module tb_burst_line_engine;

    localparam int DW = 64;
    localparam int MB = 8;
    localparam int BURST = 4;
    localparam int LW = 6;
    localparam int TMO = 64;
    localparam int CYCLES_BEFORE_INITIATED = 10;
    localparam int CYCLES_BEFORE_DATA_VALID = 6;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic                req_write = 1'b0;
    logic [LW-1:0]       req_line_addr = '0;
    logic [DW*BURST-1:0] wr_line = '0;
    logic [MB*BURST-1:0] wr_line_mask = '0;
    logic [DW*BURST-1:0] rd_line;
    logic                done;
    logic                err;
    logic                br_cmd;
    logic                br_cmd_en;
    logic [7:0]          br_addr;
    logic [DW-1:0]       br_wr_data;
    logic [MB-1:0]       br_data_mask;
    logic [DW-1:0]       br_rd_data = '0;
    logic                br_rd_data_valid = 1'b0;
    logic                br_busy = 1'b1;

    burst_line_engine #(
        .DATA_BITWIDTH(DW), .DEPTH_BITWIDTH(8), .BURST_COUNT(BURST), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_line_addr(req_line_addr), .wr_line(wr_line), .wr_line_mask(wr_line_mask),
        .rd_line(rd_line), .done(done), .err(err),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
        .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
        .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid), .br_busy(br_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                wr;
        logic [LW-1:0]     line;
        logic [DW*BURST-1:0] data;
        logic [MB*BURST-1:0] mask;
        logic [DW*BURST-1:0] exp_rd;
        bit                exp_err;
    } txn_t;

    txn_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    logic [DW*BURST-1:0] ref_mem [64];
    logic [DW*BURST-1:0] ref_last_rd = '0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- BurstRAM model ----------------
    logic [DW-1:0] mem [256];
    int  cyc = 0;
    int  since_rst = 0;
    bit  force_busy = 0, rand_busy = 0, rd_gaps = 0, stray_en = 0, rd_kill = 0;
    bit  rd_pend = 0, wr_act = 0;
    int  rd_start = 0, rd_beat = 0, wr_beat = 0, last_valid_cyc = 0;
    logic [7:0] rd_base = '0, wr_base = '0;
    int  idx;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            since_rst = 0;
            rd_pend = 0;
            wr_act = 0;
            br_busy = 1'b1;
            br_rd_data_valid = 1'b0;
            br_rd_data = '0;
        end else begin
            since_rst++;
            br_busy = (since_rst <= CYCLES_BEFORE_INITIATED) || force_busy ||
                      (rand_busy && ($urandom_range(0, 3) == 0));
            br_rd_data_valid = 1'b0;
            br_rd_data = '0;
            if (rd_pend && (cyc >= rd_start) && !(rd_gaps && ($urandom_range(0, 2) == 0))) begin
                br_rd_data_valid = 1'b1;
                idx = int'(rd_base) + rd_beat;
                br_rd_data = mem[idx];
                if (rd_beat == BURST - 1) begin
                    rd_pend = 0;
                    last_valid_cyc = cyc;
                end
                rd_beat++;
            end else if (!rd_pend && stray_en && ($urandom_range(0, 4) == 0)) begin
                br_rd_data_valid = 1'b1;
                br_rd_data = {$urandom, $urandom};
            end
            #1;
            if (br_cmd_en) begin
                if (br_cmd) begin
                    wr_act = 1;
                    wr_base = br_addr;
                    wr_beat = 0;
                end else if (!rd_kill) begin
                    rd_pend = 1;
                    rd_base = br_addr;
                    rd_beat = 0;
                    rd_start = cyc + CYCLES_BEFORE_DATA_VALID;
                end
            end
            if (wr_act) begin
                idx = int'(wr_base) + wr_beat;
                for (int b = 0; b < MB; b++)
                    if (!br_data_mask[b]) mem[idx][b*8 +: 8] = br_wr_data[b*8 +: 8];
                wr_beat++;
                if (wr_beat == BURST) wr_act = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    bit cmd_seen = 0;
    int cmd_cyc = 0;

    always @(negedge clk) begin
        txn_t t;
        int k;
        #2;
        if (!rst) begin
            cmd_seen = 0;
        end else begin
            if (sb.size() == 0) chk("req_ready_idle", req_ready, 1);
            else                chk("req_ready_busy", req_ready, 0);
            if (br_busy) chk("cmd_en_while_busy", br_cmd_en, 0);
            if (br_cmd_en) begin
                if (sb.size() == 0) begin
                    chk("cmd_en_no_request", br_cmd_en, 0);
                end else begin
                    chk("dup_cmd_en", cmd_seen, 0);
                    chk("br_cmd", br_cmd, sb[0].wr);
                    chk("br_addr", br_addr, {sb[0].line, 2'b00});
                    cmd_seen = 1;
                    cmd_cyc = cyc;
                end
            end
            if (sb.size() > 0 && sb[0].wr && cmd_seen && (cyc - cmd_cyc) < BURST) begin
                k = cyc - cmd_cyc;
                chk("wr_beat_data", br_wr_data, sb[0].data[k*DW +: DW]);
                chk("wr_beat_mask", br_data_mask, sb[0].mask[k*MB +: MB]);
            end
            if (done || err) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", done, 0);
                    chk("spurious_err", err, 0);
                end else begin
                    t = sb.pop_front();
                    chk("done_pulse", done, !t.exp_err);
                    chk("err_pulse", err, t.exp_err);
                    chk("cmd_before_end", cmd_seen, 1);
                    chk("rd_line", rd_line, t.exp_rd);
                    if (t.exp_err)   chk("timeout_latency", cyc - cmd_cyc, TMO);
                    else if (t.wr)   chk("write_latency", cyc - cmd_cyc, BURST);
                    else             chk("read_latency", cyc - last_valid_cyc, 1);
                    cmd_seen = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input bit wr, input logic [LW-1:0] line, input logic [DW*BURST-1:0] data,
                         input logic [MB*BURST-1:0] mask, input bit exp_err, input bit hold);
        txn_t t;
        bit acc = 0;
        @(negedge clk); #3;
        req_valid = 1'b1;
        req_write = wr;
        req_line_addr = line;
        wr_line = data;
        wr_line_mask = mask;
        for (int i = 0; i < 300 && !acc; i++) begin
            if (req_ready) begin
                @(posedge clk); #1;
                t.wr = wr; t.line = line; t.data = data; t.mask = mask; t.exp_err = exp_err;
                if (wr) begin
                    for (int b = 0; b < MB*BURST; b++)
                        if (!mask[b]) ref_mem[line][b*8 +: 8] = data[b*8 +: 8];
                    t.exp_rd = ref_last_rd;
                end else begin
                    t.exp_rd = exp_err ? ref_last_rd : ref_mem[line];
                    ref_last_rd = t.exp_rd;
                end
                sb.push_back(t);
                acc = 1;
            end else begin
                @(negedge clk); #3;
            end
        end
        chk("request_accepted", acc, 1);
        if (!hold) begin
            req_valid = 1'b0;
            wr_line = {8{$urandom}};
            wr_line_mask = $urandom;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk); #3;
        chk("drain_queue_empty", sb.size(), 0);
    endtask

    function automatic logic [DW*BURST-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [DW*BURST-1:0] l3, l3b, d;
        logic [MB*BURST-1:0] m;
        bit found;
        l3  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        l3b = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'hAAAA_AAAA_2222_2222, 64'h1111_1111_1111_1111};

        @(negedge clk); #3;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cmd_en", br_cmd_en, 0);
        chk("rst_cmd", br_cmd, 0);
        chk("rst_addr", br_addr, 0);
        chk("rst_wr_data", br_wr_data, 0);
        chk("rst_mask", br_data_mask, 0);
        chk("rst_rd_line", rd_line, 0);
        repeat (2) @(negedge clk);
        #3 rst = 1'b1;

        // write line 3 straight out of reset while the RAM is still busy
        issue(1, 6'd3, l3, '0, 0, 0);
        drain(100);
        issue(0, 6'd3, '0, '0, 0, 0);
        drain(100);
        chk("t2_rd_line", rd_line, l3);

        // partial write of beat 1 only
        issue(1, 6'd3, {4{64'hAAAA_AAAA_AAAA_AAAA}}, 32'hFFFF_0FFF, 0, 0);
        drain(100);
        issue(0, 6'd3, '0, '0, 0, 0);
        drain(100);
        chk("t3_rd_line", rd_line, l3b);

        // req_valid held high through a transfer with the inputs changing underneath
        d = rand_line();
        issue(1, 6'd5, d, '0, 0, 1);
        req_write = 1'b0;
        req_line_addr = 6'd9;
        wr_line = rand_line();
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk); #3;
            if (done) found = 1;
        end
        req_valid = 1'b0;
        chk("t4_done_seen", found, 1);
        drain(20);
        issue(0, 6'd5, '0, '0, 0, 0);
        drain(100);

        // read watchdog
        rd_kill = 1;
        issue(0, 6'd3, '0, '0, 1, 0);
        drain(200);
        rd_kill = 0;

        // reset in the middle of a write burst
        d = rand_line();
        issue(1, 6'd63, d, '0, 0, 0);
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk); #3;
            if (br_cmd_en) found = 1;
        end
        chk("t6_cmd_en_seen", found, 1);
        @(negedge clk);
        @(negedge clk); #3;
        chk("t6_beat2_data", br_wr_data, d[2*DW +: DW]);
        rst = 1'b0;
        #1;
        chk("t6_async_cmd_en", br_cmd_en, 0);
        chk("t6_async_done", done, 0);
        chk("t6_async_err", err, 0);
        chk("t6_async_ready", req_ready, 1);
        chk("t6_async_wr_data", br_wr_data, 0);
        chk("t6_async_addr", br_addr, 0);
        chk("t6_async_rd_line", rd_line, 0);
        sb.delete();
        ref_last_rd = '0;
        repeat (2) @(negedge clk);
        #3 rst = 1'b1;
        issue(0, 6'd3, '0, '0, 0, 0);
        drain(100);

        // randomized traffic with busy stalls, read gaps and stray read beats
        rand_busy = 1;
        rd_gaps = 1;
        stray_en = 1;
        for (int n = 0; n < 40; n++) begin
            m = ($urandom_range(0, 2) == 0) ? '0 : MB*BURST'($urandom);
            issue(bit'($urandom_range(0, 1)), LW'($urandom_range(0, 47)), rand_line(), m, 0, 0);
        end
        drain(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_errors);
        $fatal(1);
    end

endmodule
